bwt_req_arbiter: RTL

BWT_REQ_ARBITER -- requirements
Module: bwt_req_arbiter

---
 rtl/bwt_req_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/bwt_req_arbiter.sv
// bwt_req_arbiter: two per-pipeline request FIFOs feeding one memory port as round-robin k/l address pairs
module bwt_req_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = 42,
  parameter int READ_NUM_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_req_valid,
  input  logic [ADDR_W-1:0]         f_addr_k,
  input  logic [ADDR_W-1:0]         f_addr_l,
  input  logic [READ_NUM_WIDTH-1:0] f_read_num,
  input  logic                      b_req_valid,
  input  logic [ADDR_W-1:0]         b_addr_k,
  input  logic [ADDR_W-1:0]         b_addr_l,
  input  logic [READ_NUM_WIDTH-1:0] b_read_num,
  output logic                      stall_f,
  output logic                      stall_b,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [READ_NUM_WIDTH+1:0] mem_tag,
  output logic                      overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;
  state_t                    state_q;
  logic                      last_q, overflow_q, valid_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [READ_NUM_WIDTH+1:0] tag_q;
  logic [ADDR_W-1:0]         ak_q [2][FIFO_DEPTH];
  logic [ADDR_W-1:0]         al_q [2][FIFO_DEPTH];
  logic [READ_NUM_WIDTH-1:0] rn_q [2][FIFO_DEPTH];
  logic [AW-1:0]             rd_q [2];
  logic [AW-1:0]             wr_q [2];
  logic [AW:0]               cnt_q [2];
  logic [ADDR_W-1:0]         in_k [2];
  logic [ADDR_W-1:0]         in_l [2];
  logic [READ_NUM_WIDTH-1:0] in_rn [2];
  logic [1:0]                vld, push, pop, drop, ne;
  logic                      regrant, pick;
  logic [AW-1:0]             hi;
  assign vld   = {b_req_valid, f_req_valid};
  assign in_k  = '{f_addr_k, b_addr_k};
  assign in_l  = '{f_addr_l, b_addr_l};
  assign in_rn = '{f_read_num, b_read_num};
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    ne   = '0;
    for (int s = 0; s < 2; s++) begin
      pop[s]  = state_q == ISSUE_L && mem_req_ready && last_q == 1'(s);
      push[s] = vld[s] && (cnt_q[s] != (AW+1)'(FIFO_DEPTH) || pop[s]);
      drop[s] = vld[s] && !push[s];
      ne[s]   = (cnt_q[s] - (AW+1)'(pop[s])) != '0;
    end
  end
  // Emptiness is judged after this cycle's pop; same-cycle pushes are picked up from IDLE.
  assign regrant = state_q == IDLE || (state_q == ISSUE_L && mem_req_ready);
  assign pick    = (ne[0] && ne[1]) ? ~last_q : ne[1];
  assign hi      = rd_q[pick] + AW'(pop[pick]);
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (push[s]) begin
        ak_q[s][wr_q[s]] <= in_k[s];
        al_q[s][wr_q[s]] <= in_l[s];
        rn_q[s][wr_q[s]] <= in_rn[s];
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      tag_q      <= '0;
      for (int s = 0; s < 2; s++) begin
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_q[s] <= wr_q[s] + AW'(1);
        if (pop[s]) rd_q[s] <= rd_q[s] + AW'(1);
        cnt_q[s] <= cnt_q[s] + (AW+1)'(push[s]) - (AW+1)'(pop[s]);
      end
      if (|drop) overflow_q <= 1'b1;
      if (regrant && |ne) begin
        state_q <= ISSUE_K;
        valid_q <= 1'b1;
        last_q  <= pick;
        addr_q  <= ak_q[pick][hi];
        tag_q   <= {pick, 1'b0, rn_q[pick][hi]};
      end else if (regrant) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else if (state_q == ISSUE_K && mem_req_ready) begin
        state_q <= ISSUE_L;
        addr_q  <= al_q[last_q][rd_q[last_q]];
        tag_q   <= {last_q, 1'b1, rn_q[last_q][rd_q[last_q]]};
      end
    end
  end
  assign stall_f       = cnt_q[0] >= (AW+1)'(FIFO_DEPTH - 2);
  assign stall_b       = cnt_q[1] >= (AW+1)'(FIFO_DEPTH - 2);
  assign mem_req_valid = valid_q;
  assign mem_addr      = addr_q;
  assign mem_tag       = tag_q;
  assign overflow      = overflow_q;
endmodule
